ctrl_regfile: RTL and testbench
===============================

Name: ctrl_regfile

Overview:
- Control-register file for the Dioptase pipeline. Read combinationally in decode; written in writeback.
- Holds the privilege mode, process ID, interrupt status and mask, exception PC and flags, TLB fault address, and clock-divider value.
- Drives kmode, pid, cdv and the masked interrupt vector back to decode and the memory system.

Parameters:
- NUM_IRQ, 16, number of interrupt lines; ISR/IMR low-bit width.
- PID_W, 12, process-ID width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  global clock enable; no state changes when 0
- r_b  in  5  control-register read index
- cr_d  out  32  read data for r_b
- cr_we  in  1  software write enable (crmov to cr in writeback)
- target_1  in  5  write index
- write_data_1  in  32  write data
- stall  in  1  pipeline stall
- exc_in_wb  in  1  exception retiring in writeback
- tlb_exc_in_wb  in  1  that exception is a TLB fault
- tlb_addr  in  32  faulting virtual address
- epc  in  32  PC to save on exception/interrupt
- efg  in  32  flags to save on exception/interrupt
- interrupts  in  NUM_IRQ  raw interrupt request lines (level, sampled)
- interrupt_in_wb  in  1  interrupt being taken in writeback
- rfe_in_wb  in  1  return-from-exception retiring
- rfi_in_wb  in  1  return-from-interrupt retiring
- kmode  out  1  1 = kernel mode
- cdv  out  32  clock-divider value
- interrupt_state  out  32  pending & enabled interrupts, zero-extended
- pid  out  PID_W  current process ID

Behaviour:
- Register map:
  - cr0 PSR: bit0 = kmode, bit1 = saved mode.
  - cr1 PID: low 12 bits.
  - cr2 ISR: pending, low 16 bits.
  - cr3 IMR: bits15:0 = mask, bit31 = global enable (GIE).
  - cr4 EPC, cr5 EFG, cr6 TLBADDR, cr7 KSP scratch, cr8 CDV: 32 bits each.
  - cr9–cr31 read 0 and ignore writes.
  - Unimplemented bits read 0.
- Reset (rst=1 at posedge, regardless of clk_en): PSR = 1 (kernel mode, saved mode 0); every other register = 0.
- Read path: cr_d = register[r_b], purely combinational.
- Outputs: kmode = PSR[0], pid = PID[11:0], cdv = CDV.
  - interrupt_state = GIE ? {16'b0, ISR & IMR[15:0]} : 0.
  - Combinational from registered state.
- Interrupt capture: every posedge with clk_en=1, ISR |= interrupts. Capture ignores stall, so no request is lost.
- All other updates require clk_en=1 and stall=0. Within one cycle, apply in this order; later steps win on the same bits:
  1. Software write: if cr_we, register[target_1] <= write_data_1, masked to implemented bits. A write to ISR replaces it; the same-cycle interrupts are still OR-ed in.
  2. rfe_in_wb: PSR[0] <= PSR[1].
  3. rfi_in_wb: PSR[0] <= PSR[1]; GIE <= 1.
  4. exc_in_wb or interrupt_in_wb:
     - EPC <= epc; EFG <= efg; PSR <= {old PSR[0], 1}; GIE <= 0.
     - If tlb_exc_in_wb also: TLBADDR <= tlb_addr.
  5. interrupt_in_wb: clear the highest-numbered set bit of (ISR & IMR[15:0]), i.e. the one decode reported. This clear beats the same-cycle capture on that bit.
- tlb_exc_in_wb without exc_in_wb: ignored.
- Simultaneous rfe/rfi with exception entry: entry wins for PSR and GIE.
- Latency: every write is visible on cr_d and the outputs the cycle after the edge (see the optional feature).

Optional Feature:
- Macro CREG_BYPASS_EN.
- Defined: when cr_we=1, stall=0, clk_en=1 and target_1==r_b (1..8), cr_d returns write_data_1, masked to implemented bits, in the same cycle.
- Undefined: cr_d shows only registered state.
- kmode, pid, cdv and interrupt_state are never bypassed.

Test Plan:
- Reset, then read cr0..cr8 -> PSR=1, kmode=1, all others 0, interrupt_state=0.
- cr_we to target 1 with 0xFFFFF123 -> next cycle pid=0x123, cr_d(r_b=1)=0x00000123.
- Write IMR=0x80000005; raise interrupts=0x0004 for one cycle -> ISR=0x4, interrupt_state=0x4. Then pulse interrupt_in_wb with epc=0x400 -> ISR=0, EPC=0x400, GIE=0, kmode=1, PSR=0b11.
- From user mode (PSR=0), exc_in_wb+tlb_exc_in_wb with tlb_addr=0xDEAD0000, efg=0x9 -> kmode=1, PSR=0b01, TLBADDR=0xDEAD0000, EFG=9. Then rfe_in_wb -> kmode=0.
- stall=1 with cr_we to CDV=0x10 and interrupts=0x8000 -> CDV unchanged, ISR bit15 set. clk_en=0 -> nothing changes.
- With CREG_BYPASS_EN: cr_we target 8 = 0x55, r_b=8 -> cr_d=0x55 in the same cycle. Without the macro -> old value that cycle, 0x55 the next.

Source files
------------

// File: rtl/ctrl_regfile.sv
// Control-register file: PSR, PID, ISR, IMR/GIE, EPC, EFG, TLBADDR, KSP, CDV.
// Define CREG_BYPASS_EN to forward a same-cycle software write to cr_d.
module ctrl_regfile #(
    parameter int NUM_IRQ = 16,
    parameter int PID_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic [4:0]         r_b,
    output logic [31:0]        cr_d,
    input  logic               cr_we,
    input  logic [4:0]         target_1,
    input  logic [31:0]        write_data_1,
    input  logic               stall,
    input  logic               exc_in_wb,
    input  logic               tlb_exc_in_wb,
    input  logic [31:0]        tlb_addr,
    input  logic [31:0]        epc,
    input  logic [31:0]        efg,
    input  logic [NUM_IRQ-1:0] interrupts,
    input  logic               interrupt_in_wb,
    input  logic               rfe_in_wb,
    input  logic               rfi_in_wb,
    output logic               kmode,
    output logic [31:0]        cdv,
    output logic [31:0]        interrupt_state,
    output logic [PID_W-1:0]   pid
);

    logic [1:0]         psr_reg, psr_next;
    logic [PID_W-1:0]   pid_reg, pid_next;
    logic [NUM_IRQ-1:0] isr_reg, isr_next;
    logic [NUM_IRQ-1:0] imr_reg, imr_next;
    logic               gie_reg, gie_next;
    logic [31:0]        epc_reg, epc_next;
    logic [31:0]        efg_reg, efg_next;
    logic [31:0]        tlb_addr_reg, tlb_addr_next;
    logic [31:0]        ksp_reg, ksp_next;
    logic [31:0]        cdv_reg, cdv_next;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] clr_onehot;
    logic [31:0]        cr_view;
    logic               upd;

    assign upd     = clk_en && !stall;
    assign pending = isr_reg & imr_reg;

    // Isolate the highest-numbered pending line: the one decode just reported.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
            assign clr_onehot[gi] = pending[gi] && !(|(pending >> (gi + 1)));
        end
    endgenerate

    always_comb begin
        psr_next      = psr_reg;
        pid_next      = pid_reg;
        isr_next      = isr_reg;
        imr_next      = imr_reg;
        gie_next      = gie_reg;
        epc_next      = epc_reg;
        efg_next      = efg_reg;
        tlb_addr_next = tlb_addr_reg;
        ksp_next      = ksp_reg;
        cdv_next      = cdv_reg;
        if (upd) begin
            if (cr_we) begin
                case (target_1)
                    5'd0: psr_next = write_data_1[1:0];
                    5'd1: pid_next = write_data_1[PID_W-1:0];
                    5'd2: isr_next = write_data_1[NUM_IRQ-1:0];
                    5'd3: begin
                        imr_next = write_data_1[NUM_IRQ-1:0];
                        gie_next = write_data_1[31];
                    end
                    5'd4: epc_next      = write_data_1;
                    5'd5: efg_next      = write_data_1;
                    5'd6: tlb_addr_next = write_data_1;
                    5'd7: ksp_next      = write_data_1;
                    5'd8: cdv_next      = write_data_1;
                    default: ;
                endcase
            end
            if (rfe_in_wb) begin
                psr_next[0] = psr_next[1];
            end
            if (rfi_in_wb) begin
                psr_next[0] = psr_next[1];
                gie_next    = 1'b1;
            end
            // Entry saves the mode that was live this cycle and forces kernel mode.
            if (exc_in_wb || interrupt_in_wb) begin
                epc_next = epc;
                efg_next = efg;
                psr_next = {psr_reg[0], 1'b1};
                gie_next = 1'b0;
                if (tlb_exc_in_wb) begin
                    tlb_addr_next = tlb_addr;
                end
            end
        end
        if (clk_en) begin
            isr_next = isr_next | interrupts;
        end
        if (upd && interrupt_in_wb) begin
            isr_next = isr_next & ~clr_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psr_reg      <= 2'b01;
            pid_reg      <= '0;
            isr_reg      <= '0;
            imr_reg      <= '0;
            gie_reg      <= 1'b0;
            epc_reg      <= '0;
            efg_reg      <= '0;
            tlb_addr_reg <= '0;
            ksp_reg      <= '0;
            cdv_reg      <= '0;
        end else begin
            psr_reg      <= psr_next;
            pid_reg      <= pid_next;
            isr_reg      <= isr_next;
            imr_reg      <= imr_next;
            gie_reg      <= gie_next;
            epc_reg      <= epc_next;
            efg_reg      <= efg_next;
            tlb_addr_reg <= tlb_addr_next;
            ksp_reg      <= ksp_next;
            cdv_reg      <= cdv_next;
        end
    end

    always_comb begin
        case (r_b)
            5'd0:    cr_view = {30'b0, psr_reg};
            5'd1:    cr_view = 32'(pid_reg);
            5'd2:    cr_view = 32'(isr_reg);
            5'd3:    cr_view = {gie_reg, 31'(imr_reg)};
            5'd4:    cr_view = epc_reg;
            5'd5:    cr_view = efg_reg;
            5'd6:    cr_view = tlb_addr_reg;
            5'd7:    cr_view = ksp_reg;
            5'd8:    cr_view = cdv_reg;
            default: cr_view = 32'b0;
        endcase
    end

`ifdef CREG_BYPASS_EN
    logic [31:0] wr_bits;
    logic        byp_hit;

    always_comb begin
        case (r_b)
            5'd1:    wr_bits = 32'((64'd1 << PID_W) - 64'd1);
            5'd2:    wr_bits = 32'((64'd1 << NUM_IRQ) - 64'd1);
            5'd3:    wr_bits = 32'((64'd1 << NUM_IRQ) - 64'd1) | 32'h8000_0000;
            5'd4, 5'd5, 5'd6, 5'd7, 5'd8: wr_bits = 32'hFFFF_FFFF;
            default: wr_bits = 32'b0;
        endcase
    end

    assign byp_hit = cr_we && upd && (target_1 == r_b) && (r_b >= 5'd1) && (r_b <= 5'd8);
    assign cr_d    = byp_hit ? (write_data_1 & wr_bits) : cr_view;
`else
    assign cr_d = cr_view;
`endif

    assign kmode           = psr_reg[0];
    assign pid             = pid_reg;
    assign cdv             = cdv_reg;
    assign interrupt_state = gie_reg ? 32'(isr_reg & imr_reg) : 32'b0;

endmodule

// File: tb/tb_ctrl_regfile.sv
// Directed bench for ctrl_regfile: hand-computed register values after each
// writeback event, including stall / clock-enable gating and interrupt priority.
module tb_ctrl_regfile;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [4:0]  r_b;
    logic [31:0] cr_d;
    logic        cr_we;
    logic [4:0]  target_1;
    logic [31:0] write_data_1;
    logic        stall;
    logic        exc_in_wb;
    logic        tlb_exc_in_wb;
    logic [31:0] tlb_addr;
    logic [31:0] epc;
    logic [31:0] efg;
    logic [15:0] interrupts;
    logic        interrupt_in_wb;
    logic        rfe_in_wb;
    logic        rfi_in_wb;
    logic        kmode;
    logic [31:0] cdv;
    logic [31:0] interrupt_state;
    logic [11:0] pid;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_regfile #(.NUM_IRQ(16), .PID_W(12)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .r_b(r_b), .cr_d(cr_d),
        .cr_we(cr_we), .target_1(target_1), .write_data_1(write_data_1),
        .stall(stall), .exc_in_wb(exc_in_wb), .tlb_exc_in_wb(tlb_exc_in_wb),
        .tlb_addr(tlb_addr), .epc(epc), .efg(efg), .interrupts(interrupts),
        .interrupt_in_wb(interrupt_in_wb), .rfe_in_wb(rfe_in_wb),
        .rfi_in_wb(rfi_in_wb), .kmode(kmode), .cdv(cdv),
        .interrupt_state(interrupt_state), .pid(pid)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Inputs change 1 ns after the rising edge, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        r_b = idx;
        #1;
        check(tag, cr_d, exp);
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        cr_we        = 1'b1;
        target_1     = idx;
        write_data_1 = data;
        tick();
        cr_we        = 1'b0;
    endtask

    task automatic clear_events();
        exc_in_wb       = 1'b0;
        tlb_exc_in_wb   = 1'b0;
        interrupt_in_wb = 1'b0;
        rfe_in_wb       = 1'b0;
        rfi_in_wb       = 1'b0;
        interrupts      = 16'h0;
        stall           = 1'b0;
        clk_en          = 1'b1;
    endtask

    initial begin
        rst = 1'b1; r_b = 5'd0; cr_we = 1'b0; target_1 = 5'd0; write_data_1 = 32'h0;
        tlb_addr = 32'h0; epc = 32'h0; efg = 32'h0;
        clear_events();
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd(5'd0, 32'h1, "reset_psr");
        for (int i = 1; i <= 8; i++) rd(5'(i), 32'h0, $sformatf("reset_cr%0d", i));
        check("reset_kmode", 32'(kmode), 32'h1);
        check("reset_intstate", interrupt_state, 32'h0);

        // PID write masked to 12 bits
        wr(5'd1, 32'hFFFF_F123);
        check("pid_out", 32'(pid), 32'h123);
        rd(5'd1, 32'h0000_0123, "pid_read");

        // Unimplemented register ignores writes
        wr(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, 32'h0, "cr9_zero");

        // IMR write masked, then capture two lines
        wr(5'd3, 32'hFFFF_0005 & 32'h8000_FFFF | 32'h0);
        rd(5'd3, 32'h8000_0005, "imr_read");
        wr(5'd3, 32'h7FFF_0005);
        rd(5'd3, 32'h0000_0005, "imr_mask_bits");
        wr(5'd3, 32'h8000_0005);
        interrupts = 16'h0005;
        tick();
        interrupts = 16'h0;
        rd(5'd2, 32'h5, "isr_capture");
        check("intstate_pending", interrupt_state, 32'h5);

        // Interrupt entry clears only the highest pending line (bit 2)
        interrupt_in_wb = 1'b1; epc = 32'h400; efg = 32'h77;
        tick();
        interrupt_in_wb = 1'b0;
        rd(5'd2, 32'h1, "isr_after_irq");
        rd(5'd4, 32'h400, "epc_irq");
        rd(5'd5, 32'h77, "efg_irq");
        rd(5'd0, 32'h3, "psr_irq");
        rd(5'd3, 32'h5, "gie_cleared");
        check("kmode_irq", 32'(kmode), 32'h1);
        check("intstate_gie_off", interrupt_state, 32'h0);

        // Return from interrupt re-enables GIE
        rfi_in_wb = 1'b1;
        tick();
        rfi_in_wb = 1'b0;
        rd(5'd0, 32'h3, "psr_rfi");
        rd(5'd3, 32'h8000_0005, "gie_rfi");
        check("intstate_rfi", interrupt_state, 32'h1);

        // Drop to user mode, take a TLB exception
        wr(5'd0, 32'hFFFF_FFFC);
        check("kmode_user", 32'(kmode), 32'h0);
        exc_in_wb = 1'b1; tlb_exc_in_wb = 1'b1; tlb_addr = 32'hDEAD_0000;
        efg = 32'h9; epc = 32'h123;
        tick();
        exc_in_wb = 1'b0; tlb_exc_in_wb = 1'b0;
        check("kmode_exc", 32'(kmode), 32'h1);
        rd(5'd0, 32'h1, "psr_exc");
        rd(5'd6, 32'hDEAD_0000, "tlbaddr_exc");
        rd(5'd5, 32'h9, "efg_exc");
        rd(5'd4, 32'h123, "epc_exc");
        rd(5'd3, 32'h5, "gie_exc");

        rfe_in_wb = 1'b1;
        tick();
        rfe_in_wb = 1'b0;
        check("kmode_rfe", 32'(kmode), 32'h0);
        rd(5'd0, 32'h0, "psr_rfe");

        // TLB flag alone is ignored
        tlb_exc_in_wb = 1'b1; tlb_addr = 32'h1234_5678; epc = 32'h999;
        tick();
        tlb_exc_in_wb = 1'b0;
        rd(5'd6, 32'hDEAD_0000, "tlb_only_ignored");
        rd(5'd4, 32'h123, "epc_tlb_only");

        // Stall blocks writes but not capture
        stall = 1'b1; interrupts = 16'h8000;
        wr(5'd8, 32'h10);
        stall = 1'b0; interrupts = 16'h0;
        check("cdv_stall", cdv, 32'h0);
        rd(5'd2, 32'h8001, "isr_stall_capture");

        // Clock enable low freezes everything
        clk_en = 1'b0; interrupts = 16'h0002;
        wr(5'd8, 32'h20);
        clk_en = 1'b1; interrupts = 16'h0;
        check("cdv_clken", cdv, 32'h0);
        rd(5'd2, 32'h8001, "isr_clken");

        // Software ISR write replaces, same-cycle capture still ORed in
        interrupts = 16'h0001;
        wr(5'd2, 32'hFFFF_0010);
        interrupts = 16'h0;
        rd(5'd2, 32'h11, "isr_write_or");

        // Interrupt clear beats same-cycle capture on the reported bit
        wr(5'd3, 32'h8000_8000);
        interrupts = 16'h8000;
        tick();
        check("intstate_bit15", interrupt_state, 32'h8000);
        interrupt_in_wb = 1'b1; epc = 32'h500;
        tick();
        interrupt_in_wb = 1'b0; interrupts = 16'h0;
        rd(5'd2, 32'h11, "isr_clear_wins");
        rd(5'd4, 32'h500, "epc_irq2");
        rd(5'd0, 32'h3 & 32'h1 | 32'h0, "psr_irq_from_user");

        // KSP scratch full width
        wr(5'd7, 32'hCAFE_BABE);
        rd(5'd7, 32'hCAFE_BABE, "ksp_read");

        // Same-cycle read of a register being written
        r_b = 5'd8; cr_we = 1'b1; target_1 = 5'd8; write_data_1 = 32'h55;
        #1;
`ifdef CREG_BYPASS_EN
        check("cdv_bypass_same", cr_d, 32'h55);
`else
        check("cdv_nobypass_same", cr_d, 32'h0);
`endif
        check("cdv_out_same", cdv, 32'h0);
        tick();
        cr_we = 1'b0;
        rd(5'd8, 32'h55, "cdv_next");
        check("cdv_out_next", cdv, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
